// File: rtl/l1_dcache_controller_if.sv
// Signal bundle between the L1 D-cache controller and its core, array and memory neighbours.
// The master view is the controller; the slave view is the surrounding core LSU, arrays and memory.
interface l1_dcache_controller_if #(
    parameter int TAG_W   = 2,
    parameter int INDEX_W = 11,
    parameter int WORD_W  = 3,
    parameter int DATA_W  = 16
);
    localparam int ADDR_W = TAG_W + INDEX_W + WORD_W;

    logic              CoreReq;
    logic              CoreWrite;
    logic [ADDR_W-1:0] CoreAddr;
    logic [DATA_W-1:0] CoreWData;
    logic              CoreReady;
    logic              CoreDone;
    logic [DATA_W-1:0] CoreRData;
    logic              CoreHit;

    logic [INDEX_W-1:0] ArrIndex;
    logic [WORD_W-1:0]  ArrWordSel;
    logic               ArrValid;
    logic               ArrDirty;
    logic [TAG_W-1:0]   ArrTag;
    logic [DATA_W-1:0]  ArrRData;
    logic               ArrWe;
    logic [DATA_W-1:0]  ArrWData;
    logic               ArrMetaWe;
    logic [TAG_W-1:0]   ArrMetaTag;
    logic               ArrMetaValid;
    logic               ArrMetaDirty;

    logic              MemReq;
    logic              MemWrite;
    logic [ADDR_W-1:0] MemAddr;
    logic [DATA_W-1:0] MemWData;
    logic              MemAck;
    logic [DATA_W-1:0] MemRData;

    modport master (
        input  CoreReq, CoreWrite, CoreAddr, CoreWData,
        output CoreReady, CoreDone, CoreRData, CoreHit,
        output ArrIndex, ArrWordSel, ArrWe, ArrWData,
        output ArrMetaWe, ArrMetaTag, ArrMetaValid, ArrMetaDirty,
        input  ArrValid, ArrDirty, ArrTag, ArrRData,
        output MemReq, MemWrite, MemAddr, MemWData,
        input  MemAck, MemRData
    );

    modport slave (
        output CoreReq, CoreWrite, CoreAddr, CoreWData,
        input  CoreReady, CoreDone, CoreRData, CoreHit,
        input  ArrIndex, ArrWordSel, ArrWe, ArrWData,
        input  ArrMetaWe, ArrMetaTag, ArrMetaValid, ArrMetaDirty,
        output ArrValid, ArrDirty, ArrTag, ArrRData,
        input  MemReq, MemWrite, MemAddr, MemWData,
        output MemAck, MemRData
    );
endinterface

// File: rtl/l1_dcache_controller.sv
// Sequencer for a direct-mapped write-back L1 data cache: tag check, dirty victim write-back
// and word-serial refill against externally held, combinationally read cache arrays.
module l1_dcache_controller #(
    parameter int TAG_W   = 2,
    parameter int INDEX_W = 11,
    parameter int WORD_W  = 3,
    parameter int DATA_W  = 16
) (
    input  logic                   clk,
    input  logic                   reset,
    l1_dcache_controller_if.master bus
);
    // state  | meaning
    // IDLE   | ready for a core access; CoreDone of the previous access shows here
    // LOOKUP | tag compare against the latched address
    // WBACK  | stream the dirty victim block to memory, one word per MemAck
    // INVAL  | clear valid/dirty so a partially refilled block never looks valid
    // REFILL | fetch the requested block from memory into the data array
    // UPDATE | install the new tag as valid and clean, then retry the lookup

    localparam int ADDR_W = TAG_W + INDEX_W + WORD_W;
    localparam logic [WORD_W-1:0] LAST_WORD = '1;

    typedef enum logic [2:0] {
        IDLE   = 3'd0,
        LOOKUP = 3'd1,
        WBACK  = 3'd2,
        INVAL  = 3'd3,
        REFILL = 3'd4,
        UPDATE = 3'd5
    } state_t;

    state_t             state, stateNext;
    logic [WORD_W-1:0]  cnt, cntNext;

    logic               reqWrite;
    logic [TAG_W-1:0]   reqTag;
    logic [INDEX_W-1:0] reqIndex;
    logic [WORD_W-1:0]  reqWord;
    logic [DATA_W-1:0]  reqWData;
    logic               missFlag;

    logic               coreDone;
    logic               coreHit;
    logic [DATA_W-1:0]  coreRData;

    logic               hit;

    logic [WORD_W-1:0]  arrWordSel;
    logic               arrWe;
    logic [DATA_W-1:0]  arrWData;
    logic               arrMetaWe;
    logic               arrMetaValid;
    logic               arrMetaDirty;
    logic               memReq;
    logic               memWrite;
    logic [ADDR_W-1:0]  memAddr;

    assign hit = bus.ArrValid && (bus.ArrTag == reqTag);

    always_ff @(posedge clk) begin
        if (reset) begin
            state     <= IDLE;
            cnt       <= '0;
            reqWrite  <= 1'b0;
            reqTag    <= '0;
            reqIndex  <= '0;
            reqWord   <= '0;
            reqWData  <= '0;
            missFlag  <= 1'b0;
            coreDone  <= 1'b0;
            coreHit   <= 1'b0;
            coreRData <= '0;
        end else begin
            state    <= stateNext;
            cnt      <= cntNext;
            coreDone <= 1'b0;
            case (state)
                IDLE: begin
                    if (bus.CoreReq) begin
                        reqWrite <= bus.CoreWrite;
                        {reqTag, reqIndex, reqWord} <= bus.CoreAddr;
                        reqWData <= bus.CoreWData;
                        missFlag <= 1'b0;
                    end
                end
                LOOKUP: begin
                    if (hit) begin
                        coreDone <= 1'b1;
                        coreHit  <= ~missFlag;
                        if (!reqWrite) begin
                            coreRData <= bus.ArrRData;
                        end
                    end else begin
                        missFlag <= 1'b1;
                    end
                end
                default: ;
            endcase
        end
    end

    always_comb begin
        stateNext    = state;
        cntNext      = cnt;
        arrWordSel   = reqWord;
        arrWe        = 1'b0;
        arrWData     = reqWData;
        arrMetaWe    = 1'b0;
        arrMetaValid = 1'b0;
        arrMetaDirty = 1'b0;
        memReq       = 1'b0;
        memWrite     = 1'b0;
        memAddr      = {reqTag, reqIndex, cnt};
        case (state)
            IDLE: begin
                if (bus.CoreReq) begin
                    stateNext = LOOKUP;
                end
            end
            LOOKUP: begin
                if (hit) begin
                    stateNext = IDLE;
                    if (reqWrite) begin
                        arrWe        = 1'b1;
                        arrMetaWe    = 1'b1;
                        arrMetaValid = 1'b1;
                        arrMetaDirty = 1'b1;
                    end
                end else begin
                    cntNext   = '0;
                    stateNext = (bus.ArrValid && bus.ArrDirty) ? WBACK : INVAL;
                end
            end
            WBACK: begin
                // Victim tag still sits in the tag array; nothing is rewritten until INVAL.
                arrWordSel = cnt;
                memReq     = 1'b1;
                memWrite   = 1'b1;
                memAddr    = {bus.ArrTag, reqIndex, cnt};
                if (bus.MemAck) begin
                    cntNext = cnt + 1'b1;
                    if (cnt == LAST_WORD) begin
                        stateNext = INVAL;
                    end
                end
            end
            INVAL: begin
                arrMetaWe = 1'b1;
                stateNext = REFILL;
            end
            REFILL: begin
                arrWordSel = cnt;
                memReq     = 1'b1;
                arrWData   = bus.MemRData;
                if (bus.MemAck) begin
                    arrWe   = 1'b1;
                    cntNext = cnt + 1'b1;
                    if (cnt == LAST_WORD) begin
                        stateNext = UPDATE;
                    end
                end
            end
            UPDATE: begin
                arrMetaWe    = 1'b1;
                arrMetaValid = 1'b1;
                stateNext    = LOOKUP;
            end
            default: stateNext = IDLE;
        endcase
    end

    assign bus.CoreReady    = (state == IDLE);
    assign bus.CoreDone     = coreDone;
    assign bus.CoreHit      = coreHit;
    assign bus.CoreRData    = coreRData;

    assign bus.ArrIndex     = reqIndex;
    assign bus.ArrWordSel   = arrWordSel;
    assign bus.ArrWe        = arrWe;
    assign bus.ArrWData     = arrWData;
    assign bus.ArrMetaWe    = arrMetaWe;
    assign bus.ArrMetaTag   = reqTag;
    assign bus.ArrMetaValid = arrMetaValid;
    assign bus.ArrMetaDirty = arrMetaDirty;

    assign bus.MemReq       = memReq;
    assign bus.MemWrite     = memWrite;
    assign bus.MemAddr      = memAddr;
    assign bus.MemWData     = bus.ArrRData;
endmodule

// File: tb/tb_l1_dcache_controller.sv
// Bench for l1_dcache_controller: behavioural arrays and memory around the DUT, a flat-memory
// plus tag-directory reference model, a directed vector table, random accesses and corner sequences.
module tb_l1_dcache_controller;
    localparam int TAG_W   = 2;
    localparam int INDEX_W = 11;
    localparam int WORD_W  = 3;
    localparam int DATA_W  = 16;

    logic clk = 1'b0;
    logic reset = 1'b1;
    logic initEnv = 1'b1;
    always #5 clk = ~clk;

    l1_dcache_controller_if #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .WORD_W(WORD_W), .DATA_W(DATA_W)) bus ();

    l1_dcache_controller #(.TAG_W(TAG_W), .INDEX_W(INDEX_W), .WORD_W(WORD_W), .DATA_W(DATA_W)) dut (
        .clk   (clk),
        .reset (reset),
        .bus   (bus)
    );

    int checks = 0;
    int errors = 0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [15:0] pat(input int a);
        return 16'(a) ^ 16'hA5C3;
    endfunction

    // ---------------- environment: cache arrays and main memory ----------------
    typedef struct {
        logic        w;
        logic [15:0] a;
        logic [15:0] d;
    } op_t;

    logic [15:0] arrData [16384];
    logic [1:0]  arrTag [2048];
    logic        arrValid [2048];
    logic        arrDirty [2048];
    logic [15:0] mem [65536];
    int          ackWait = 0;
    int          waitCnt = 0;
    int          stabErrs = 0;
    logic        stabPending = 1'b0;
    logic        stabW = 1'b0;
    logic [15:0] stabA = '0;
    logic [15:0] stabD = '0;
    op_t         memLog[$];
    op_t         arrLog[$];
    op_t         metaLog[$];

    assign bus.ArrValid = arrValid[bus.ArrIndex];
    assign bus.ArrDirty = arrDirty[bus.ArrIndex];
    assign bus.ArrTag   = arrTag[bus.ArrIndex];
    assign bus.ArrRData = arrData[{bus.ArrIndex, bus.ArrWordSel}];
    assign bus.MemAck   = bus.MemReq && (waitCnt >= ackWait);
    assign bus.MemRData = mem[bus.MemAddr];

    always @(posedge clk) begin
        if (initEnv) begin
            for (int i = 0; i < 65536; i++) mem[i] <= pat(i);
            for (int i = 0; i < 16384; i++) arrData[i] <= '0;
            for (int i = 0; i < 2048; i++) begin
                arrTag[i]   <= '0;
                arrValid[i] <= 1'b0;
                arrDirty[i] <= 1'b0;
            end
        end else begin
            if (bus.MemReq && bus.MemAck) begin
                memLog.push_back('{bus.MemWrite, bus.MemAddr, bus.MemWData});
                if (bus.MemWrite) mem[bus.MemAddr] <= bus.MemWData;
            end
            if (bus.ArrWe) begin
                arrData[{bus.ArrIndex, bus.ArrWordSel}] <= bus.ArrWData;
                arrLog.push_back('{1'b1, {2'b00, bus.ArrIndex, bus.ArrWordSel}, bus.ArrWData});
            end
            if (bus.ArrMetaWe) begin
                arrTag[bus.ArrIndex]   <= bus.ArrMetaTag;
                arrValid[bus.ArrIndex] <= bus.ArrMetaValid;
                arrDirty[bus.ArrIndex] <= bus.ArrMetaDirty;
                metaLog.push_back('{1'b1, {5'b0, bus.ArrIndex},
                                    {12'b0, bus.ArrMetaTag, bus.ArrMetaValid, bus.ArrMetaDirty}});
            end
        end
        if (reset || !bus.MemReq || bus.MemAck) waitCnt <= 0;
        else waitCnt <= waitCnt + 1;
        // A waiting memory request must not change its address, direction or write data.
        if (stabPending && bus.MemReq && !reset &&
            (bus.MemAddr !== stabA || bus.MemWrite !== stabW || (bus.MemWrite && bus.MemWData !== stabD)))
            stabErrs <= stabErrs + 1;
        stabPending <= bus.MemReq && !bus.MemAck && !reset;
        stabA <= bus.MemAddr;
        stabW <= bus.MemWrite;
        stabD <= bus.MemWData;
    end

    // ---------------- reference model: flat memory + tag directory ----------------
    logic [15:0] gold [65536];
    logic [1:0]  refTag [2048];
    logic        refValid [2048];
    logic        refDirty [2048];
    logic [15:0] lastRData = '0;

    task automatic access(input logic wr, input logic [15:0] addr, input logic [15:0] wd, input int w,
                          output logic gotHit, output logic [15:0] gotRData, output int busy, output int ops);
        logic [1:0]  tag, vTag;
        int          idx, word, n, m0, a0, t0, nExp, cnt;
        logic        expHit, expWb;
        logic [15:0] expRData;
        int          expBusy;
        tag      = addr[15:14];
        idx      = int'(addr[13:3]);
        word     = int'(addr[2:0]);
        expHit   = refValid[idx] && refTag[idx] == tag;
        expWb    = !expHit && refValid[idx] && refDirty[idx];
        vTag     = refTag[idx];
        expRData = wr ? lastRData : gold[int'(addr)];
        expBusy  = expHit ? 1 : 4 + 8 * (w + 1) + (expWb ? 8 * (w + 1) : 0);
        m0 = memLog.size();
        a0 = arrLog.size();
        t0 = metaLog.size();
        ackWait = w;

        @(negedge clk);
        n = 0;
        while (!bus.CoreReady && n < 100) begin
            @(negedge clk);
            n++;
        end
        check("ready_before_req", bus.CoreReady, 1);
        bus.CoreReq   = 1'b1;
        bus.CoreWrite = wr;
        bus.CoreAddr  = addr;
        bus.CoreWData = wd;
        @(posedge clk);
        #1 bus.CoreReq = 1'b0;
        busy = 0;
        n = 0;
        @(negedge clk);
        while (!bus.CoreDone && n < 5000) begin
            if (!bus.CoreReady) busy++;
            n++;
            @(negedge clk);
        end
        check("done_within_bound", n < 5000, 1);
        gotHit   = bus.CoreHit;
        gotRData = bus.CoreRData;
        check("model_hit", gotHit, expHit);
        check("model_rdata", gotRData, expRData);
        check("model_busy_cycles", busy, expBusy);

        nExp = (expWb ? 8 : 0) + (expHit ? 0 : 8);
        ops = memLog.size() - m0;
        check("mem_op_count", ops, nExp);
        for (int i = 0; i < nExp && i < ops; i++) begin
            logic expW;
            int   expA;
            expW = expWb && i < 8;
            expA = expW ? int'(vTag) * 16384 + idx * 8 + i : int'(tag) * 16384 + idx * 8 + (i % 8);
            check("mem_op_write", memLog[m0 + i].w, expW);
            check("mem_op_addr", memLog[m0 + i].a, expA);
            if (expW) check("wb_data", memLog[m0 + i].d, gold[expA]);
        end

        nExp = (expHit ? 0 : 8) + (wr ? 1 : 0);
        cnt = arrLog.size() - a0;
        check("arr_write_count", cnt, nExp);
        for (int i = 0; i < nExp && i < cnt; i++) begin
            if (!expHit && i < 8) begin
                check("refill_sel", arrLog[a0 + i].a, idx * 8 + i);
                check("refill_data", arrLog[a0 + i].d, gold[int'(tag) * 16384 + idx * 8 + i]);
            end else begin
                check("store_sel", arrLog[a0 + i].a, idx * 8 + word);
                check("store_data", arrLog[a0 + i].d, wd);
            end
        end

        nExp = (expHit ? 0 : 2) + (wr ? 1 : 0);
        cnt = metaLog.size() - t0;
        check("meta_write_count", cnt, nExp);
        for (int i = 0; i < nExp && i < cnt; i++) begin
            check("meta_index", metaLog[t0 + i].a, idx);
            if (!expHit && i == 0) check("meta_inval", metaLog[t0 + i].d[1:0], 2'b00);
            else if (!expHit && i == 1) check("meta_update", metaLog[t0 + i].d[3:0], {tag, 2'b10});
            else check("meta_store", metaLog[t0 + i].d[3:0], {tag, 2'b11});
        end

        if (!expHit) begin
            refValid[idx] = 1'b1;
            refTag[idx]   = tag;
            refDirty[idx] = 1'b0;
        end
        if (wr) begin
            refDirty[idx]     = 1'b1;
            gold[int'(addr)]  = wd;
        end else begin
            lastRData = expRData;
        end
    endtask

    // ---------------- directed vector table ----------------
    typedef struct {
        logic        wr;
        logic [15:0] addr;
        logic [15:0] wd;
        int          w;
        logic        expHit;
        logic [15:0] expRData;
        int          expBusy;
        int          expOps;
    } vec_t;

    vec_t vecs [9];

    initial begin
        #900000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        logic        gh;
        logic [15:0] gr;
        int          gb, go, n, k, lastDone, m0;
        logic [15:0] b2b [3];

        bus.CoreReq   = 1'b0;
        bus.CoreWrite = 1'b0;
        bus.CoreAddr  = '0;
        bus.CoreWData = '0;
        for (int i = 0; i < 65536; i++) gold[i] = pat(i);
        for (int i = 0; i < 2048; i++) begin
            refTag[i]   = '0;
            refValid[i] = 1'b0;
            refDirty[i] = 1'b0;
        end

        vecs[0] = '{1'b0, 16'h0010, 16'h0000, 0, 1'b0, pat(16'h0010), 12, 8};
        vecs[1] = '{1'b1, 16'h0013, 16'hBEEF, 0, 1'b1, pat(16'h0010), 1, 0};
        vecs[2] = '{1'b0, 16'h8013, 16'h0000, 0, 1'b0, pat(16'h8013), 20, 16};
        vecs[3] = '{1'b0, 16'h0013, 16'h0000, 3, 1'b0, 16'hBEEF, 36, 8};
        vecs[4] = '{1'b0, 16'h0017, 16'h0000, 2, 1'b1, pat(16'h0017), 1, 0};
        vecs[5] = '{1'b1, 16'h1FFF, 16'h1234, 0, 1'b0, pat(16'h0017), 12, 8};
        vecs[6] = '{1'b0, 16'h1FFF, 16'h0000, 0, 1'b1, 16'h1234, 1, 0};
        vecs[7] = '{1'b0, 16'hDFFF, 16'h0000, 1, 1'b0, pat(16'hDFFF), 36, 16};
        vecs[8] = '{1'b0, 16'h1FFF, 16'h0000, 0, 1'b0, 16'h1234, 12, 8};

        repeat (3) @(posedge clk);
        #1 initEnv = 1'b0;
        @(negedge clk);
        check("rst_core_done", bus.CoreDone, 0);
        check("rst_core_hit", bus.CoreHit, 0);
        check("rst_core_rdata", bus.CoreRData, 0);
        check("rst_mem_req", bus.MemReq, 0);
        check("rst_arr_we", bus.ArrWe, 0);
        check("rst_arr_meta_we", bus.ArrMetaWe, 0);
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("rst_core_ready", bus.CoreReady, 1);

        for (int v = 0; v < 9; v++) begin
            access(vecs[v].wr, vecs[v].addr, vecs[v].wd, vecs[v].w, gh, gr, gb, go);
            check("vec_hit", gh, vecs[v].expHit);
            check("vec_rdata", gr, vecs[v].expRData);
            check("vec_busy", gb, vecs[v].expBusy);
            check("vec_mem_ops", go, vecs[v].expOps);
        end

        for (int r = 0; r < 60; r++) begin
            logic [15:0] ra;
            int          sel;
            sel = $urandom_range(0, 2);
            ra[15:14] = 2'($urandom_range(0, 3));
            ra[13:3]  = (sel == 0) ? 11'h005 : (sel == 1) ? 11'h006 : 11'h7FF;
            ra[2:0]   = 3'($urandom_range(0, 7));
            access($urandom_range(0, 1) == 1, ra, 16'($urandom), $urandom_range(0, 2), gh, gr, gb, go);
        end

        // Back-to-back hitting loads with CoreReq held high throughout.
        access(1'b0, 16'h4000, 16'h0000, 0, gh, gr, gb, go);
        b2b[0] = 16'h4001;
        b2b[1] = 16'h4005;
        b2b[2] = 16'h4007;
        m0 = memLog.size();
        @(negedge clk);
        bus.CoreReq   = 1'b1;
        bus.CoreWrite = 1'b0;
        bus.CoreAddr  = b2b[0];
        k = 0;
        n = 0;
        lastDone = 0;
        while (k < 3 && n < 40) begin
            @(negedge clk);
            n++;
            if (bus.CoreDone) begin
                check("b2b_rdata", bus.CoreRData, gold[int'(b2b[k])]);
                check("b2b_hit", bus.CoreHit, 1);
                check("b2b_gap", n - lastDone, 2);
                lastDone = n;
                k++;
                if (k < 3) bus.CoreAddr = b2b[k];
                else bus.CoreReq = 1'b0;
            end
        end
        bus.CoreReq = 1'b0;
        check("b2b_done_count", k, 3);
        check("b2b_no_mem_traffic", memLog.size() - m0, 0);
        lastRData = gold[int'(b2b[2])];

        // Reset while the refill is on word 4.
        ackWait = 0;
        @(negedge clk);
        bus.CoreReq   = 1'b1;
        bus.CoreWrite = 1'b0;
        bus.CoreAddr  = 16'h2020;
        @(posedge clk);
        #1 bus.CoreReq = 1'b0;
        n = 0;
        @(negedge clk);
        while (!(bus.MemReq && !bus.MemWrite && bus.MemAddr[2:0] == 3'd4) && n < 200) begin
            @(negedge clk);
            n++;
        end
        check("reached_refill_word4", n < 200, 1);
        reset = 1'b1;
        @(posedge clk);
        #1 reset = 1'b0;
        @(negedge clk);
        check("midrst_mem_req", bus.MemReq, 0);
        check("midrst_core_ready", bus.CoreReady, 1);
        check("midrst_arr_we", bus.ArrWe, 0);
        check("midrst_arr_meta_we", bus.ArrMetaWe, 0);
        check("midrst_core_rdata", bus.CoreRData, 0);
        check("partial_refill_invalid", arrValid[11'h404], 0);
        refValid[11'h404] = 1'b0;
        lastRData = '0;
        access(1'b0, 16'h2020, 16'h0000, 0, gh, gr, gb, go);
        check("reload_hit", gh, 0);
        check("reload_rdata", gr, pat(16'h2020));
        check("reload_mem_ops", go, 8);

        check("mem_stable_violations", stabErrs, 0);
        $display("Simulation finished: %0d checks, %0d errors", checks, errors);
        $finish;
    end
endmodule
